// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: fetches a missing cache block one word at a time from main memory
// and writes each word into the victim way of the data storage.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   miss, miss_addr        miss request and the byte address that missed (sampled in IDLE)
//   victim_way             way to refill, latched together with miss
//   mem_req, mem_addr      word read request and its word-aligned byte address
//   mem_ack, mem_rdata     read data valid strobe and read data
//   fill_we                one-cycle write strobe into data storage
//   fill_way, fill_word    target way and word index; hold while fill_we is low
//   fill_data              word to write; holds while fill_we is low
//   stall                  high whenever the engine is busy
//   refill_done            one-cycle pulse once the whole block is written
module cache_refill_ctrl #(
    parameter  int ADDR_W          = 32,
    parameter  int DATA_W          = 32,
    parameter  int WORDS_PER_BLOCK = 4,
    parameter  int WAYS            = 4,
    localparam int WAY_W           = $clog2(WAYS),
    localparam int CNT_W           = $clog2(WORDS_PER_BLOCK)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              miss,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic [WAY_W-1:0]  victim_way,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fill_we,
    output logic [WAY_W-1:0]  fill_way,
    output logic [CNT_W-1:0]  fill_word,
    output logic [DATA_W-1:0] fill_data,
    output logic              stall,
    output logic              refill_done
);

    localparam int OFF_W = $clog2(WORDS_PER_BLOCK * 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FILL,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAY_W-1:0]  way_q, way_d;
    logic [WAY_W-1:0]  fill_way_q, fill_way_d;
    logic [CNT_W-1:0]  fill_word_q, fill_word_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_word;

    // The byte offset inside the block never reaches memory.
    logic addr_lsb_unused;
    assign addr_lsb_unused = ^miss_addr[OFF_W-1:0];

    assign last_word = (cnt_q == CNT_W'(WORDS_PER_BLOCK - 1));

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        way_d       = way_q;
        fill_way_d  = fill_way_q;
        fill_word_d = fill_word_q;
        data_d      = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (miss) begin
                    base_d  = {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    way_d   = victim_way;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // The fill target is updated on the same edge as the data,
                // so the fill outputs only ever change together.
                if (mem_ack) begin
                    data_d      = mem_rdata;
                    fill_way_d  = way_q;
                    fill_word_d = cnt_q;
                    state_d     = S_FILL;
                end
            end
            S_FILL: begin
                if (last_word) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            cnt_q       <= '0;
            way_q       <= '0;
            fill_way_q  <= '0;
            fill_word_q <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            way_q       <= way_d;
            fill_way_q  <= fill_way_d;
            fill_word_q <= fill_word_d;
            data_q      <= data_d;
        end
    end

    assign mem_req     = (state_q == S_REQ);
    assign mem_addr    = base_q + ADDR_W'({cnt_q, 2'b00});
    assign fill_we     = (state_q == S_FILL);
    assign fill_way    = fill_way_q;
    assign fill_word   = fill_word_q;
    assign fill_data   = data_q;
    assign stall       = (state_q != S_IDLE);
    assign refill_done = (state_q == S_DONE);

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: randomized scoreboard bench for cache_refill_ctrl.
// Driver plays miss source and memory; a monitor checks fills and done pulses.
module tb_cache_refill_ctrl;

    localparam int W = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        miss = 1'b0;
    logic [31:0] miss_addr = '0;
    logic [1:0]  victim_way = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        fill_we;
    logic [1:0]  fill_way;
    logic [1:0]  fill_word;
    logic [31:0] fill_data;
    logic        stall;
    logic        refill_done;

    cache_refill_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .miss       (miss),
        .miss_addr  (miss_addr),
        .victim_way (victim_way),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .fill_we    (fill_we),
        .fill_way   (fill_way),
        .fill_word  (fill_word),
        .fill_data  (fill_data),
        .stall      (stall),
        .refill_done(refill_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] way;
        logic [31:0] word;
        logic [31:0] data;
    } fill_t;

    fill_t fill_q[$];
    int    done_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        check({name, "_req"}, 32'(mem_req), 0);
        check({name, "_addr"}, mem_addr, 0);
        check({name, "_we"}, 32'(fill_we), 0);
        check({name, "_way"}, 32'(fill_way), 0);
        check({name, "_word"}, 32'(fill_word), 0);
        check({name, "_data"}, fill_data, 0);
        check({name, "_stall"}, 32'(stall), 0);
        check({name, "_done"}, 32'(refill_done), 0);
    endtask

    // Monitor: every fill or done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (fill_we) begin
                if (fill_q.size() == 0) begin
                    check("fill_unexpected", 32'(fill_we), 0);
                end else begin
                    fill_t e;
                    e = fill_q.pop_front();
                    check("fill_way", 32'(fill_way), e.way);
                    check("fill_word", 32'(fill_word), e.word);
                    check("fill_data", fill_data, e.data);
                end
            end
            if (refill_done) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 32'(refill_done), 0);
                end else begin
                    int ec;
                    ec = done_q.pop_front();
                    check("done_cycle", 32'(cyc), 32'(ec));
                end
            end
        end
    end

    task automatic start_miss(input logic [31:0] addr, input logic [1:0] way,
                              output int e0);
        miss_addr  = addr;
        victim_way = way;
        miss       = 1'b1;
        tick();
        e0      = cyc;
        miss    = 1'b0;
        mem_ack = 1'b0;
    endtask

    task automatic noise();
        miss       = 1'($urandom);
        miss_addr  = $urandom;
        victim_way = 2'($urandom);
    endtask

    // Plays memory for one block. Returns in the DONE cycle, or in the
    // REQ cycle of word abort_at when aborting.
    task automatic serve_block(input logic [31:0] addr, input logic [1:0] way,
                               input int e0, input int dmin, input int dmax,
                               input bit noisy, input bit seq,
                               input int abort_at, output bit aborted);
        logic [31:0] base, exp_addr, data;
        int          dsum, d, guard;
        base    = addr & ~32'(W * 4 - 1);
        dsum    = 0;
        aborted = 1'b0;
        for (int i = 0; i < W; i++) begin
            guard = 0;
            while (!mem_req && guard < 40) begin
                tick();
                guard++;
            end
            if (!mem_req) begin
                check("req_timeout", 32'(mem_req), 1);
                aborted = 1'b1;
                return;
            end
            if (i == abort_at) begin
                aborted = 1'b1;
                return;
            end
            exp_addr = base + 32'(4 * i);
            d        = $urandom_range(dmax, dmin);
            dsum    += d;
            for (int j = 0; j <= d; j++) begin
                check("req_high", 32'(mem_req), 1);
                check("req_addr", mem_addr, exp_addr);
                check("req_stall", 32'(stall), 1);
                if (j < d) begin
                    if (noisy) noise();
                    tick();
                end
            end
            data      = seq ? 32'hA0 + 32'(i) : $urandom;
            mem_ack   = 1'b1;
            mem_rdata = data;
            fill_q.push_back('{32'(way), 32'(i), data});
            if (i == W - 1) done_q.push_back(e0 + 2 * W + dsum);
            tick();
            // FILL cycle: a stray ack here must be ignored.
            mem_ack   = noisy ? 1'($urandom) : 1'b0;
            mem_rdata = $urandom;
            if (noisy) begin
                noise();
                if (i == W - 1) miss = 1'b0;
            end
            tick();
            mem_ack = 1'b0;
            if (noisy && i == W - 1) miss = 1'b0;
        end
    endtask

    int e0;
    bit ab;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation hung at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_zero("rst_idle");
            tick();
        end

        // Directed block at 0x1234, immediate acks, known data.
        start_miss(32'h0000_1234, 2'd2, e0);
        serve_block(32'h0000_1234, 2'd2, e0, 0, 0, 1'b0, 1'b1, -1, ab);
        check("done_stall", 32'(stall), 1);
        tick();
        check("idle_stall", 32'(stall), 0);

        // Acks on the third REQ cycle of each word.
        start_miss(32'h8000_0F08, 2'd1, e0);
        serve_block(32'h8000_0F08, 2'd1, e0, 2, 2, 1'b0, 1'b0, -1, ab);
        tick();

        // Reset while waiting on word 2.
        start_miss(32'h0000_4440, 2'd3, e0);
        serve_block(32'h0000_4440, 2'd3, e0, 0, 1, 1'b0, 1'b0, 2, ab);
        check("abort_req", 32'(mem_req), 1);
        reset = 1'b1;
        #1;
        check_zero("async_rst");
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_zero("post_rst");
        start_miss(32'h0000_4440, 2'd0, e0);
        serve_block(32'h0000_4440, 2'd0, e0, 0, 1, 1'b0, 1'b0, -1, ab);
        tick();

        // Miss held high across DONE starts a second refill.
        miss_addr  = 32'h0001_0010;
        victim_way = 2'd3;
        miss       = 1'b1;
        tick();
        e0 = cyc;
        serve_block(32'h0001_0010, 2'd3, e0, 0, 0, 1'b0, 1'b0, -1, ab);
        tick();
        check("chain_idle_req", 32'(mem_req), 0);
        check("chain_idle_stall", 32'(stall), 0);
        tick();
        e0   = cyc;
        miss = 1'b0;
        check("chain_req", 32'(mem_req), 1);
        serve_block(32'h0001_0010, 2'd3, e0, 0, 2, 1'b0, 1'b0, -1, ab);
        tick();

        // Random blocks with stray acks and miss noise while busy.
        for (int n = 0; n < 20; n++) begin
            logic [31:0] a;
            logic [1:0]  w;
            int gap;
            gap = $urandom_range(3, 0);
            for (int g = 0; g < gap; g++) begin
                mem_ack   = 1'($urandom);
                mem_rdata = $urandom;
                check("idle_no_req", 32'(mem_req), 0);
                tick();
            end
            a = $urandom;
            w = 2'($urandom);
            start_miss(a, w, e0);
            serve_block(a, w, e0, 0, 3, 1'b1, 1'b0, -1, ab);
            tick();
        end

        mem_ack = 1'b0;
        repeat (4) tick();
        check("fills_left", 32'(fill_q.size()), 0);
        check("dones_left", 32'(done_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
